// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register countdown scoreboard producing RAW/WAW decode
//               stalls for ops with write-back latency up to MAX_LAT.
//               Optional stall-cycle counter: HAZARD_SCOREBOARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 4,
    parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic              rs_used,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rt_used,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              dest_we,
    input  logic [LAT_W-1:0]  dest_lat,
    output logic              stall,
    output logic              issue_fire,
    output logic              busy_any
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    input  logic              perf_clear,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int               NUM_VIEW  = 1 << ADDR_W;
    localparam logic [LAT_W-1:0] c_max_lat = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] r_cnt      [1:NUM_REGS-1];
    logic [LAT_W-1:0] w_cnt_view [NUM_VIEW];
    logic [LAT_W-1:0] w_lat_eff;
    logic             w_raw_rs;
    logic             w_raw_rt;
    logic             w_waw;
    logic             w_hazard;
    logic             w_load;
    logic             w_busy;

    // Full address-space view: r0 and untracked addresses always read as idle.
    for (genvar i = 0; i < NUM_VIEW; i++) begin : g_view
        if (i != 0 && i < NUM_REGS) begin : g_tracked
            assign w_cnt_view[i] = r_cnt[i];
        end else begin : g_zero
            assign w_cnt_view[i] = '0;
        end
    end

    always_comb begin
        w_lat_eff = (dest_lat > c_max_lat) ? c_max_lat : dest_lat;
        w_raw_rs  = rs_used && (rs_addr != '0) && (w_cnt_view[rs_addr] != '0);
        w_raw_rt  = rt_used && (rt_addr != '0) && (w_cnt_view[rt_addr] != '0);
        w_waw     = dest_we && (dest_addr != '0) && (w_cnt_view[dest_addr] > w_lat_eff);
        w_hazard  = w_raw_rs || w_raw_rt || w_waw;
    end

    assign stall      = ~rst & issue_valid & ~flush &  w_hazard;
    assign issue_fire = ~rst & issue_valid & ~flush & ~w_hazard;
    assign w_load     = issue_fire & dest_we & (dest_addr != '0) & (w_lat_eff != '0);

    always_comb begin
        w_busy = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_busy = w_busy | (r_cnt[r] != '0);
        end
    end

    assign busy_any = w_busy;

    // A new issue's latency overrides that register's decrement in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_load && (dest_addr == ADDR_W'(r))) begin
                    r_cnt[r] <= w_lat_eff;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - LAT_W'(1);
                end
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (perf_clear) begin
            r_stall_cycles <= '0;
        end else if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 24;
    localparam int ADDR_W   = 5;
    localparam int MAX_LAT  = 4;
    localparam int LAT_W    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_valid = 1'b0;
    logic              flush = 1'b0;
    logic [ADDR_W-1:0] rs_addr = '0;
    logic              rs_used = 1'b0;
    logic [ADDR_W-1:0] rt_addr = '0;
    logic              rt_used = 1'b0;
    logic [ADDR_W-1:0] dest_addr = '0;
    logic              dest_we = 1'b0;
    logic [LAT_W-1:0]  dest_lat = '0;
    logic              stall;
    logic              issue_fire;
    logic              busy_any;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic              perf_clear = 1'b0;
    logic [31:0]       stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .MAX_LAT  (MAX_LAT),
        .LAT_W    (LAT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .flush        (flush),
        .rs_addr      (rs_addr),
        .rs_used      (rs_used),
        .rt_addr      (rt_addr),
        .rt_used      (rt_used),
        .dest_addr    (dest_addr),
        .dest_we      (dest_we),
        .dest_lat     (dest_lat),
        .stall        (stall),
        .issue_fire   (issue_fire),
        .busy_any     (busy_any)
`ifdef HAZARD_SCOREBOARD_PERF_EN
        ,
        .perf_clear   (perf_clear),
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic s, input logic f, input logic b);
        check_eq({tag, ".stall"}, 32'(stall), 32'(s));
        check_eq({tag, ".fire"},  32'(issue_fire), 32'(f));
        check_eq({tag, ".busy"},  32'(busy_any), 32'(b));
    endtask

    task automatic drive(input logic v, input logic fl,
                         input logic [ADDR_W-1:0] rs, input logic rsu,
                         input logic [ADDR_W-1:0] rt, input logic rtu,
                         input logic [ADDR_W-1:0] d, input logic we,
                         input logic [LAT_W-1:0] lat);
        issue_valid = v;  flush   = fl;
        rs_addr     = rs; rs_used = rsu;
        rt_addr     = rt; rt_used = rtu;
        dest_addr   = d;  dest_we = we;
        dest_lat    = lat;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a reader of reg and expect exactly n stall cycles before it fires.
    task automatic read_wait(input string tag, input logic [ADDR_W-1:0] rg, input int n);
        drive(1'b1, 1'b0, rg, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        for (int i = 0; i < n; i++) begin
            #1;
            expect_out({tag, ".wait"}, 1'b1, 1'b0, 1'b1);
            tick();
        end
        #1;
        check_eq({tag, ".fire"}, 32'(issue_fire), 32'd1);
        tick();
    endtask

    initial begin
        idle();
        tick();
        tick();
        expect_out("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Load-use
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 3'd1);
        #1; expect_out("lu_issue", 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 3'd0);
        #1; expect_out("lu_stall", 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("lu_fire", 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        #1; expect_out("lu_idle", 1'b0, 1'b0, 1'b0);

        // Multi-cycle mul r3, lat 4
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd4);
        #1; expect_out("mul_issue", 1'b0, 1'b1, 1'b0);
        tick();
        read_wait("mul", 5'd3, 4);
        idle();
        #1; check_eq("mul_drained", 32'(busy_any), 32'd0);

`ifdef HAZARD_SCOREBOARD_PERF_EN
        check_eq("perf_count", stall_cycles, 32'd5);
        perf_clear = 1'b1;
        tick();
        perf_clear = 1'b0;
        check_eq("perf_clear", stall_cycles, 32'd0);
`endif

        // WAW: addu r3 lat 0 meets cnt[3] = 3
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd4);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #1; expect_out("waw_wait", 1'b1, 1'b0, 1'b1);
            tick();
        end
        #1; check_eq("waw_fire", 32'(issue_fire), 32'd1);
        tick();
        idle();
        #1; check_eq("waw_lat0_noentry", 32'(busy_any), 32'd0);

        // WAW boundary: cnt equal to new latency does not stall, and reloads
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd4);
        tick();
        idle();
        tick();
        tick();
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd2);
        #1; expect_out("waw_eq", 1'b0, 1'b1, 1'b1);
        tick();
        read_wait("waw_reload", 5'd4, 2);

        // Latency above MAX_LAT clamps to MAX_LAT
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3'd7);
        tick();
        read_wait("clamp", 5'd6, 4);

        // Self-dependency lw r5,0(r5)
        drive(1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 3'd1);
        #1; expect_out("self_dep", 1'b0, 1'b1, 1'b0);
        tick();
        read_wait("self_dep_rd", 5'd5, 1);

        // Zero register
        drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 3'd1);
        tick();
        drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b0, 3'd0);
        #1; expect_out("r0_read", 1'b0, 1'b1, 1'b0);
        tick();

        // Out-of-range register is never tracked
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd30, 1'b1, 3'd4);
        tick();
        drive(1'b1, 1'b0, 5'd30, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        #1; expect_out("oob_read", 1'b0, 1'b1, 1'b0);
        tick();

        // Flush: hazardous op squashed, r10 not loaded, r3 keeps counting
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd4);
        tick();
        drive(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 3'd3);
        #1; expect_out("flush", 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0, 3'd0);
        #1; expect_out("flush_noload", 1'b0, 1'b1, 1'b1);
        tick();
        read_wait("flush_decr", 5'd3, 2);

        // Asynchronous reset mid-countdown
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd4);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
        #1; expect_out("arst_pre", 1'b1, 1'b0, 1'b1);
        #1; rst = 1'b1;
        #1;
        check_eq("arst_stall", 32'(stall), 32'd0);
        check_eq("arst_busy", 32'(busy_any), 32'd0);
        #1; rst = 1'b0;
        #1; expect_out("arst_post", 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised RAW/WAW interlock for the MIPS decode stage. It generalises the single fixed load-use check into a per-register countdown scoreboard, so ops with any write-back latency up to MAX_LAT stall dependants for exactly the right number of cycles. It sits beside decode. Its stall output gates the PC/IF-ID registers and injects a bubble into ID/EX.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never tracked
ADDR_W, 5, register address width; NUM_REGS must be at most 2**ADDR_W
MAX_LAT, 4, largest latency an op can declare; LAT_W = $clog2(MAX_LAT+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
issue_valid  in  1  decode holds a valid instruction
flush  in  1  squash the instruction in decode this cycle
rs_addr  in  ADDR_W  source register 1
rs_used  in  1  instruction reads rs
rt_addr  in  ADDR_W  source register 2
rt_used  in  1  instruction reads rt
dest_addr  in  ADDR_W  write-back register
dest_we  in  1  instruction writes dest_addr
dest_lat  in  LAT_W  cycles until the result is forwardable to decode; 0 means fully forwarded (ALU), 1 means load, N means multi-cycle op
stall  out  1  hold decode and insert a bubble
issue_fire  out  1  instruction leaves decode this cycle
busy_any  out  1  at least one counter is non-zero (pipeline drain indication)

Behaviour:
- State: cnt[r] for r = 1..NUM_REGS-1, each LAT_W bits. busy[r] = (cnt[r] != 0). Register 0 always reads as cnt = 0.
- Reset (asynchronous): all cnt = 0. stall, issue_fire and busy_any are combinational, so they read 0 while rst is high.
- Effective latency: lat_eff = min(dest_lat, MAX_LAT).
- Hazard terms (all combinational):
  - raw_rs = rs_used & rs_addr != 0 & busy[rs_addr]
  - raw_rt = rt_used & rt_addr != 0 & busy[rt_addr]
  - waw = dest_we & dest_addr != 0 & cnt[dest_addr] > lat_eff
- stall = issue_valid & ~flush & (raw_rs | raw_rt | waw).
- issue_fire = issue_valid & ~flush & ~stall.
- Sequential update, every cycle, in this priority:
  - Step 1: each non-zero cnt[r] decrements by 1, saturating at 0.
  - Step 2: if issue_fire & dest_we & dest_addr != 0 & lat_eff != 0, then cnt[dest_addr] <= lat_eff. This overrides step 1 for that register.
- Timing: a dependant of an op issued with latency L at cycle t stalls for cycles t+1 .. t+L and fires at cycle t+L+1.
- Self-dependency (e.g. lw r5,0(r5)): cnt is read before the update, so the instruction does not stall on itself.
- Range rules:
  - Writes to dest_addr >= NUM_REGS are ignored.
  - Reads from rs_addr/rt_addr >= NUM_REGS are never busy.
- flush:
  - The current instruction neither stalls nor fires, and does not update the scoreboard.
  - Countdowns already in flight continue, because those ops are older and still complete.
- rst asserted mid-operation: all counters clear immediately; there is no partial state.
- busy_any = OR of all busy[r].

Optional Feature:
Macro HAZARD_SCOREBOARD_PERF_EN.
- Defined:
  - Adds output stall_cycles (out, 32 bits): count of cycles with stall = 1.
  - Saturates at 32'hFFFF_FFFF and does not wrap.
  - Cleared by rst.
  - Also adds input perf_clear (in, 1): synchronous clear that takes priority over increment.
- Not defined: neither port exists and no counter logic is generated.

Test Plan:
- Load-use: issue lw r8 with lat 1 at cycle 0; add r9,r8,r8 presented at cycle 1 -> stall = 1 for exactly cycle 1, issue_fire = 1 at cycle 2, cnt[8] = 0 afterwards.
- Multi-cycle op: mul writes r3 with lat 4; next instruction reads r3 -> stall = 1 for 4 cycles, then fires; busy_any falls together with cnt[3] reaching 0.
- WAW: mul r3 with lat 4, then addu r3 with lat 0 one cycle later (cnt[3] = 3) -> stall on waw for 3 cycles, then fires.
- Zero register and flush:
  - lw r0 with lat 1 leaves no entry, and a reader of r0 never stalls.
  - A hazardous instruction presented together with flush -> stall = 0, issue_fire = 0, counters unchanged apart from decrementing.
- Async reset: assert rst asynchronously while cnt[7] = 3 -> all counters 0 and stall = 0 immediately, without a clock edge; a reader of r7 fires in the first cycle after reset is released.
- Perf (HAZARD_SCOREBOARD_PERF_EN): the load-use scenario followed by the mul scenario -> stall_cycles = 5; perf_clear pulse -> 0 on the next edge.
